// File: rtl/hd_fifo_pkg.sv
// Shared defaults and handshake helpers for the HD valid/ready family.
package hd_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_DEPTH      = 4;

   // A beat transfers only when both sides agree at the same edge.
   function automatic logic hs_fire(input logic v, input logic r);
      return v && r;
   endfunction

endpackage

// File: rtl/hd_ram.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module hd_ram #(
   parameter  int DATA_WIDTH = 16,
   parameter  int DEPTH      = 4,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   // Storage is deliberately not reset; the control logic never exposes stale entries.
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hd_fifo.sv
// DEPTH-entry valid/ready FIFO with occupancy reporting.
// Optional same-cycle bypass when empty: define HD_FIFO_BYPASS_EN.
module hd_fifo
   import hd_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DEPTH      = DEF_DEPTH,
   localparam int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] data_src,
   output logic                  ready_output,
   output logic                  valid_output,
   output logic [DATA_WIDTH-1:0] data_dest,
   input  logic                  ready,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  push, pop, bypass;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // rst gating keeps any beat from being accepted or offered while reset is held.
   assign ready_output = !full && !rst;

`ifdef HD_FIFO_BYPASS_EN
   assign bypass = empty && valid && ready && !rst;
`else
   assign bypass = 1'b0;
`endif

   assign valid_output = (!empty || bypass) && !rst;
   assign push         = hs_fire(valid, ready_output) && !bypass;
   assign pop          = hs_fire(valid_output, ready) && !bypass;
   assign data_dest    = bypass ? data_src : (empty ? '0 : rdata);

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   hd_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) u_ram (
      .clk  (clk),
      .we   (push),
      .waddr(wr_ptr),
      .wdata(data_src),
      .raddr(rd_ptr),
      .rdata(rdata)
   );

endmodule

// File: tb/tb_hd_fifo.sv
// Directed bench for hd_fifo (DATA_WIDTH=16, DEPTH=4) with a small queue model for the toggle phase.
module tb_hd_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [15:0] data_src;
   logic        ready_output;
   logic        valid_output;
   logic [15:0] data_dest;
   logic        ready;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hd_fifo dut (
      .clk         (clk),
      .rst         (rst),
      .valid       (valid),
      .data_src    (data_src),
      .ready_output(ready_output),
      .valid_output(valid_output),
      .data_dest   (data_dest),
      .ready       (ready),
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] q[$];
      logic [15:0] nxt;
      logic        do_push, do_pop;

      rst = 1'b1; valid = 1'b0; ready = 1'b0; data_src = '0;
      #1;
      tick(); tick();
      chk("rst_count",  32'(count), 0);
      chk("rst_empty",  32'(empty), 1);
      chk("rst_full",   32'(full), 0);
      chk("rst_vout",   32'(valid_output), 0);
      chk("rst_ddest",  32'(data_dest), 0);
      chk("rst_rdyout", 32'(ready_output), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_rdyout", 32'(ready_output), 1);

      // Fill with ready low: 1..4 stored, 5 refused.
      valid = 1'b1;
      data_src = 16'd1;
      #1;
      chk("fill_vout_before", 32'(valid_output), 0);
      tick();
      chk("fill_lat_vout", 32'(valid_output), 1);
      chk("fill_lat_ddest", 32'(data_dest), 1);
      chk("fill_lat_count", 32'(count), 1);
      for (int i = 2; i <= 4; i++) begin
         data_src = 16'(i);
         tick();
      end
      chk("fill_count", 32'(count), 4);
      chk("fill_full", 32'(full), 1);
      chk("fill_rdyout", 32'(ready_output), 0);
      chk("fill_ddest", 32'(data_dest), 1);
      data_src = 16'd5;
      tick();
      chk("fill_ovf_count", 32'(count), 4);

      // Drain: full and ready high pops without pushing.
      valid = 1'b0;
      ready = 1'b1;
      #1;
      chk("drain_full_rdyout", 32'(ready_output), 0);
      for (int i = 1; i <= 4; i++) begin
         chk("drain_vout", 32'(valid_output), 1);
         chk("drain_ddest", 32'(data_dest), 32'(i));
         tick();
         if (i == 1) chk("drain_rdyout_after_pop", 32'(ready_output), 1);
      end
      chk("drain_empty", 32'(empty), 1);
      chk("drain_ddest0", 32'(data_dest), 0);
      chk("drain_vout0", 32'(valid_output), 0);
      chk("drain_count", 32'(count), 0);

      // Streaming from empty.
      valid = 1'b1;
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         data_src = 16'h0010 + 16'(i);
         #1;
`ifdef HD_FIFO_BYPASS_EN
         chk("stream_byp_ddest", 32'(data_dest), 32'(16'h0010 + 16'(i)));
         chk("stream_byp_count", 32'(count), 0);
`else
         if (i > 0) begin
            chk("stream_ddest", 32'(data_dest), 32'(16'h0010 + 16'(i - 1)));
            chk("stream_vout", 32'(valid_output), 1);
            chk("stream_count", 32'(count), 1);
         end
`endif
         tick();
      end
      valid = 1'b0;
      tick();
      chk("stream_end_empty", 32'(empty), 1);

      // Toggle ready every cycle with valid held high; queue model tracks contents.
      valid = 1'b1;
      nxt = 16'h0020;
      for (int i = 0; i < 12; i++) begin
         ready = (i % 2 == 0);
         data_src = nxt;
         #1;
         chk("tog_rdyout", 32'(ready_output), 32'(q.size() < 4));
`ifdef HD_FIFO_BYPASS_EN
         if (q.size() == 0 && ready) begin
            chk("tog_byp_ddest", 32'(data_dest), 32'(nxt));
            nxt++;
            tick();
            continue;
         end
`endif
         chk("tog_vout", 32'(valid_output), 32'(q.size() > 0));
         if (q.size() > 0) chk("tog_ddest", 32'(data_dest), 32'(q[0]));
         do_pop  = ready && (q.size() > 0);
         do_push = (q.size() < 4);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            q.push_back(nxt);
            nxt++;
         end
         tick();
      end
      chk("tog_count", 32'(count), 32'(q.size()));
      valid = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 4 && q.size() > 0; i++) begin
         #1;
         chk("tog_drain_ddest", 32'(data_dest), 32'(q[0]));
         void'(q.pop_front());
         tick();
      end
      chk("tog_drain_empty", 32'(empty), 1);

      // Mid-operation reset with count=3.
      valid = 1'b1;
      ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         data_src = 16'h0030 + 16'(i);
         tick();
      end
      chk("mrst_pre_count", 32'(count), 3);
      rst = 1'b1;
      ready = 1'b1;
      data_src = 16'h0099;
      #1;
      chk("mrst_vout", 32'(valid_output), 0);
      chk("mrst_rdyout", 32'(ready_output), 0);
      tick();
      rst = 1'b0;
      valid = 1'b0;
      ready = 1'b0;
      #1;
      chk("mrst_count", 32'(count), 0);
      chk("mrst_empty", 32'(empty), 1);
      valid = 1'b1;
      data_src = 16'h00AA;
      tick();
      valid = 1'b0;
      #1;
      chk("mrst_first_ddest", 32'(data_dest), 32'h00AA);
      chk("mrst_first_count", 32'(count), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
